// File: rtl/ntt_arith_pkg.sv
// Shared arithmetic definitions for the NTT datapath blocks (modular adder, subtractor, multiplier).
package ntt_arith_pkg;
   localparam int COEF_WIDTH_DEF = 14;
   localparam int MODULUS_DEF    = 12289;
   localparam int WORD_SIZE_DEF  = 12;
   localparam int LATENCY_MIN    = 1;
   localparam int LATENCY_MAX    = 2;

   function automatic bit latency_is_legal(input int lat);
      return (lat == LATENCY_MIN) || (lat == LATENCY_MAX);
   endfunction

   // q = {mod_high, 0...0, 1}; callers truncate to their coefficient width
   function automatic logic [31:0] build_modulus(input logic [31:0] mod_high, input int word_size);
      return (mod_high << word_size) | 32'd1;
   endfunction
endpackage

// File: rtl/modsub_pipe_check.sv
// Combinational recheck of a subtraction result: flags when (c + b) mod q differs from a.
module modadd_check
   import ntt_arith_pkg::*;
#(
   parameter int WIDTH = COEF_WIDTH_DEF
) (
   input  logic             valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] q,
   output logic             err
);
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] red_s;

   // Single conditional subtract suffices because c and b are both below q
   always_comb begin
      sum_s = {1'b0, c} + {1'b0, b};
      if (sum_s >= {1'b0, q}) begin
         red_s = sum_s[WIDTH-1:0] - q;
      end else begin
         red_s = sum_s[WIDTH-1:0];
      end
      err = valid && (red_s != a);
   end
endmodule

// File: rtl/modsub_pipe.sv
// Streaming modular subtractor c = (a - b) mod q with valid/ready flow control and inline self-check.
module modsub_pipe
   import ntt_arith_pkg::*;
#(
   parameter int WIDTH     = COEF_WIDTH_DEF,
   parameter int MODULUS   = MODULUS_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int LATENCY   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-WORD_SIZE-1:0] mod_high,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_a,
   input  logic [WIDTH-1:0]          in_b,
   input  logic                      fault_inj,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_c,
   output logic                      out_err
);
   logic [WIDTH-1:0] q_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] fault_s;
   logic             ready1_s;
   logic             ov_s;
   logic [WIDTH-1:0] oc_s;
   logic [WIDTH-1:0] oa_s;
   logic [WIDTH-1:0] ob_s;

   function automatic logic [WIDTH-1:0] borrow_fix(input logic [WIDTH:0] d, input logic [WIDTH-1:0] q);
      if (d[WIDTH]) begin
         return d[WIDTH-1:0] + q;
      end else begin
         return d[WIDTH-1:0];
      end
   endfunction

   // Modulus selection and the raw borrow-extended difference
   always_comb begin
      if (MODULUS != 0) begin
         q_s = WIDTH'(MODULUS);
      end else begin
         q_s = WIDTH'(build_modulus(32'(mod_high), WORD_SIZE));
      end
      diff_s  = {1'b0, in_a} - {1'b0, in_b};
      fault_s = {{(WIDTH-1){1'b0}}, fault_inj};
   end

   if (!latency_is_legal(LATENCY)) begin : g_bad_latency
      $error("modsub_pipe: LATENCY must be 1 or 2");
   end

   if (LATENCY == 2) begin : g_lat2
      logic             v1_r, v2_r, ready2_s;
      logic [WIDTH:0]   diff1_r;
      logic [WIDTH-1:0] a1_r, b1_r, c2_r, a2_r, b2_r;

      assign ready2_s = !v2_r || out_ready;
      assign ready1_s = !v1_r || ready2_s;

      // Stage 1 holds the raw difference; stage 2 applies the borrow correction
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v1_r    <= 1'b0;
            diff1_r <= '0;
            a1_r    <= '0;
            b1_r    <= '0;
            v2_r    <= 1'b0;
            c2_r    <= '0;
            a2_r    <= '0;
            b2_r    <= '0;
         end else begin
            if (ready1_s) begin
               v1_r <= in_valid;
               if (in_valid) begin
                  diff1_r <= diff_s;
                  a1_r    <= in_a;
                  b1_r    <= in_b;
               end
            end
            if (ready2_s) begin
               v2_r <= v1_r;
               if (v1_r) begin
                  c2_r <= borrow_fix(diff1_r, q_s) ^ fault_s;
                  a2_r <= a1_r;
                  b2_r <= b1_r;
               end
            end
         end
      end

      assign ov_s = v2_r;
      assign oc_s = c2_r;
      assign oa_s = a2_r;
      assign ob_s = b2_r;
   end else begin : g_lat1
      logic             v1_r;
      logic [WIDTH-1:0] c1_r, a1_r, b1_r;

      assign ready1_s = !v1_r || out_ready;

      // Single stage: subtract, correct and register in one step
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v1_r <= 1'b0;
            c1_r <= '0;
            a1_r <= '0;
            b1_r <= '0;
         end else if (ready1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
               c1_r <= borrow_fix(diff_s, q_s) ^ fault_s;
               a1_r <= in_a;
               b1_r <= in_b;
            end
         end
      end

      assign ov_s = v1_r;
      assign oc_s = c1_r;
      assign oa_s = a1_r;
      assign ob_s = b1_r;
   end

   modadd_check #(.WIDTH(WIDTH)) u_check (
      .valid (ov_s),
      .a     (oa_s),
      .b     (ob_s),
      .c     (oc_s),
      .q     (q_s),
      .err   (out_err)
   );

   assign in_ready  = ready1_s;
   assign out_valid = ov_s;
   assign out_c     = oc_s;
endmodule

// File: tb/tb_modsub_pipe.sv
// Directed bench for modsub_pipe: fixed q=12289 two-stage instance and runtime q=3329 one-stage instance.
module tb_modsub_pipe;
   localparam int Q1 = 12289;
   localparam int Q2 = 3329;

   typedef struct {int a; int b; int c;} vec_t;
   typedef struct {int c; int err;} exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic [13:0] a1, b1, oc1;
   logic [1:0]  mh1;
   logic        v1, r1, f1, ov1, ordy1, oe1;
   logic [11:0] a2, b2, oc2;
   logic [3:0]  mh2;
   logic        v2, r2, f2, ov2, ordy2, oe2;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pops1    = 0;
   int   cyc      = 0;
   exp_t q1[$];
   exp_t q2[$];
   vec_t t1[10];
   vec_t t2[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   modsub_pipe #(.WIDTH(14), .MODULUS(12289), .WORD_SIZE(12), .LATENCY(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .mod_high(mh1), .in_valid(v1), .in_ready(r1),
      .in_a(a1), .in_b(b1), .fault_inj(f1), .out_valid(ov1), .out_ready(ordy1),
      .out_c(oc1), .out_err(oe1));

   modsub_pipe #(.WIDTH(12), .MODULUS(0), .WORD_SIZE(8), .LATENCY(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .mod_high(mh2), .in_valid(v2), .in_ready(r2),
      .in_a(a2), .in_b(b2), .fault_inj(f2), .out_valid(ov2), .out_ready(ordy2),
      .out_c(oc2), .out_err(oe2));

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push(input int sel, input int a, input int b, input int c, input int err);
      int   n;
      exp_t e;
      e.c = c;
      e.err = err;
      if (sel == 1) begin
         a1 = a[13:0]; b1 = b[13:0]; v1 = 1'b1; q1.push_back(e);
      end else begin
         a2 = a[11:0]; b2 = b[11:0]; v2 = 1'b1; q2.push_back(e);
      end
      n = 0;
      while (!((sel == 1) ? r1 : r2) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("push_timeout", n, 0);
      @(posedge clk); #1;
      if (sel == 1) v1 = 1'b0;
      else v2 = 1'b0;
   endtask

   task automatic latency(input int sel, input int a, input int b, input int c, input int lat);
      int k;
      push(sel, a, b, c, 0);
      k = 1;
      while (!((sel == 1) ? ov1 : ov2) && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      check((sel == 1) ? "latency_dut1" : "latency_dut2", k, lat);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("drain_timeout", n, 0);
   endtask

   // Output scoreboards: a pop is a negedge with valid and ready both high
   always @(negedge clk) begin
      if (rst_n && ov1 && ordy1) begin
         pops1++;
         if (q1.size() == 0) begin
            check("dut1_unexpected_out", 1, 0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("dut1_out_c", int'(oc1), e.c);
            check("dut1_out_err", int'(oe1), e.err);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov2 && ordy2) begin
         if (q2.size() == 0) begin
            check("dut2_unexpected_out", 1, 0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            check("dut2_out_c", int'(oc2), e.c);
            check("dut2_out_err", int'(oe2), e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, base, a, b;
      t1[0] = '{5, 3, 2};          t1[1] = '{3, 5, 12287};
      t1[2] = '{0, 12288, 1};      t1[3] = '{7, 7, 0};
      t1[4] = '{12288, 0, 12288};  t1[5] = '{12288, 12288, 0};
      t1[6] = '{1, 12288, 2};      t1[7] = '{100, 40, 60};
      t1[8] = '{6000, 9000, 9289}; t1[9] = '{12288, 1, 12287};
      t2[0] = '{1, 2, 3328};       t2[1] = '{3328, 0, 3328};
      t2[2] = '{0, 3328, 1};       t2[3] = '{100, 100, 0};
      t2[4] = '{2000, 3000, 2329}; t2[5] = '{3328, 3328, 0};

      rst_n = 1'b0;
      a1 = '0; b1 = '0; v1 = 1'b0; f1 = 1'b0; ordy1 = 1'b1; mh1 = 2'd0;
      a2 = '0; b2 = '0; v2 = 1'b0; f2 = 1'b0; ordy2 = 1'b1; mh2 = 4'hD;
      #12;
      check("rst_out_valid1", int'(ov1), 0);
      check("rst_out_c1", int'(oc1), 0);
      check("rst_out_err1", int'(oe1), 0);
      check("rst_out_valid2", int'(ov2), 0);
      check("rst_out_c2", int'(oc2), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("rst_in_ready1", int'(r1), 1);
      check("rst_in_ready2", int'(r2), 1);

      latency(1, 5, 3, 2, 2);
      wait_drain();
      for (int i = 0; i < 10; i++) push(1, t1[i].a, t1[i].b, t1[i].c, 0);
      wait_drain();

      // Full-throughput burst against a golden (a - b) mod q
      base = pops1;
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin
         a = int'($urandom_range(0, Q1 - 1));
         b = int'($urandom_range(0, Q1 - 1));
         push(1, a, b, (a >= b) ? a - b : a - b + Q1, 0);
      end
      check("burst_cycles", cyc - t0, 16);
      wait_drain();
      check("burst_pops", pops1 - base, 16);

      // Fault injected while the middle item enters the final stage
      push(1, 10, 3, 7, 0);
      push(1, 100, 40, 61, 1);
      f1 = 1'b1;
      push(1, 20, 30, 12279, 0);
      f1 = 1'b0;
      wait_drain();

      // Backpressure: two items fill the pipe, third must wait
      ordy1 = 1'b0;
      push(1, 50, 20, 30, 0);
      push(1, 20, 50, 12259, 0);
      check("bp_in_ready_full", int'(r1), 0);
      a1 = 14'd12288; b1 = 14'd12287; v1 = 1'b1;
      q1.push_back('{1, 0});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_in_ready_hold", int'(r1), 0);
         check("bp_out_valid_hold", int'(ov1), 1);
         check("bp_out_c_hold", int'(oc1), 30);
      end
      ordy1 = 1'b1;
      #1;
      check("bp_release_in_ready", int'(r1), 1);
      @(posedge clk); #1;
      v1 = 1'b0;
      wait_drain();

      // Reset with two items in flight
      push(1, 9, 4, 5, 0);
      push(1, 4, 9, 12284, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(ov1), 0);
      check("midrst_out_c", int'(oc1), 0);
      check("midrst_out_err", int'(oe1), 0);
      q1.delete();
      q2.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready", int'(r1), 1);
      latency(1, 9, 4, 5, 2);
      wait_drain();

      // Runtime modulus instance, single stage
      latency(2, 1, 2, 3328, 1);
      wait_drain();
      for (int i = 0; i < 6; i++) push(2, t2[i].a, t2[i].b, t2[i].c, 0);
      for (int i = 0; i < 6; i++) begin
         a = int'($urandom_range(0, Q2 - 1));
         b = int'($urandom_range(0, Q2 - 1));
         push(2, a, b, (a >= b) ? a - b : a - b + Q2, 0);
      end
      wait_drain();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/modsub_pipe.md
Name: modsub_pipe

Overview:
- Streaming modular subtractor: c = (a - b) mod q, q = {mod_high, 0…0, 1} (same modulus encoding as the NTT modular adder).
- Sits on the difference leg of the NTT/INTT butterfly, opposite the adder.
- Adds valid/ready flow control with backpressure.
- Adds an inline self-check that recomputes (c + b) mod q and compares it against a, flagging mismatches for fault detection.

Parameters:
- WIDTH, 14, coefficient width in bits.
- MODULUS, 12289, fixed modulus; 0 selects runtime modulus built from mod_high.
- WORD_SIZE, 12, number of low modulus bits forced to 0…01; q = {MOD_HIGH, (WORD_SIZE-1)'b0, 1'b1}.
- LATENCY, 2, number of register stages; legal values are 1 or 2 only, anything else is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mod_high  in  WIDTH-WORD_SIZE  runtime modulus high bits; used only when MODULUS==0; must be stable while any valid is in flight.
- in_valid  in  1  input handshake valid.
- in_ready  out  1  input handshake ready.
- in_a  in  WIDTH  minuend, required < q.
- in_b  in  WIDTH  subtrahend, required < q.
- fault_inj  in  1  verification hook; flips bit 0 of the result entering the final stage.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_c  out  WIDTH  (a - b) mod q.
- out_err  out  1  self-check mismatch; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits clear, so out_valid=0 and out_err=0.
  - Data registers are also cleared to 0, so out_c=0.
  - in_ready=1 one combinational evaluation after reset release.
- Transfer rules:
  - A transfer occurs on a clk edge where valid && ready.
  - Stage k loads when ready_k = !valid_k || ready_{k+1}, with ready_{LATENCY+1} = out_ready.
  - in_ready = ready_1; the ready path is combinational and has no skid buffer.
- Arithmetic:
  - diff = {1'b0,a} - {1'b0,b} in WIDTH+1 bits.
  - If diff[WIDTH]==1 (borrow), c = diff + q truncated to WIDTH bits; otherwise c = diff[WIDTH-1:0].
  - a==b yields 0; a=0, b=q-1 yields 1.
- LATENCY=2:
  - Stage 1 registers diff, borrow, a and b.
  - Stage 2 registers the corrected c (XOR fault_inj on bit 0), plus a and b for the check.
- LATENCY=1:
  - Subtraction and correction are combinational into the single stage, which registers c, a and b.
- Self-check (combinational on the output stage):
  - s = c + b in WIDTH+1 bits; r = (s >= q) ? s - q : s.
  - out_err = out_valid && (r[WIDTH-1:0] != a).
- Timing and flow:
  - With no backpressure, the result appears LATENCY cycles after the input transfer.
  - Full throughput is one result per cycle.
  - While out_valid && !out_ready, out_c and out_err hold stable; upstream stages fill and in_ready drops once all stages are valid.
  - Simultaneous output pop and input push at full occupancy is allowed (stage ready chains through); no bubble is inserted.
- Inputs ≥ q give an undefined out_c; out_err may assert and no further guarantee is made.
- Reset asserted mid-stream drops all in-flight items immediately; nothing is replayed.
- Runtime modulus: changing mod_high while valid is in flight is illegal; behaviour is undefined.

Decomposition:
- Shared package ntt_arith_pkg holds:
  - function build_modulus(mod_high) returning the WIDTH-bit q.
  - constant LEGAL_LATENCY set.
  - shared coefficient width default (14) and default modulus 12289.
  - These are reused by the modular adder and multiplier.
- One sub-module, modadd_check, is natural: a combinational (c + b) mod q comparator producing the mismatch bit.
- The pipeline and handshake stay in modsub_pipe.

Test Plan:
- MODULUS=12289, LATENCY=2, out_ready=1:
  - a=5, b=3 -> out_c=2 two cycles later, out_err=0.
  - a=3, b=5 -> out_c=12287.
  - a=0, b=12288 -> out_c=1.
- Back-to-back 16 random reduced pairs with out_ready=1 -> 16 consecutive out_valid cycles, results match a golden (a - b) mod q, in order, out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 after 2 accepted items, out_c stable, no loss or duplication; on release, results drain in order.
- fault_inj=1 for one item (a=100, b=40) -> out_c=61, out_err=1 on exactly that item only.
- MODULUS=0, WORD_SIZE=8, WIDTH=12, mod_high=0xD (q=3329): a=1, b=2 -> out_c=3328; LATENCY=1 gives the result one cycle after transfer.
- Assert rst_n=0 with 2 items in flight -> out_valid drops asynchronously, out_c=0; after release, the first new item completes normally.
